// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI responder: status word layout,
// command bits, default fill byte and FSM state encoding.
package spi_slave_pkg;

  localparam int RXF     = 15;
  localparam int OVR     = 14;
  localparam int SEL     = 13;
  localparam int TXE     = 8;
  localparam int CMD_ACK = 15;

  localparam logic [7:0] FILL_DEFAULT = 8'hFF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-flop synchronizer for an asynchronous pin, with a history flop that
// turns the synchronized level into single-cycle rise/fall strobes.
module spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stage_reg;
  logic                   hist_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg <= {SYNC_STAGES{RST_VAL}};
      hist_reg  <= RST_VAL;
    end else begin
      stage_reg[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
      hist_reg <= stage_reg[SYNC_STAGES-1];
    end
  end

  assign level = stage_reg[SYNC_STAGES-1];
  assign rise  = level & ~hist_reg;
  assign fall  = ~level & hist_reg;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI responder with a CPU load/in/out word interface. SPI pins are
// oversampled in the clk domain; all state lives here except the synchronizers.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter logic [7:0] FILL        = FILL_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] in,
  output logic [15:0] out,
  input  logic        CSX,
  input  logic        SCK,
  input  logic        SDI,
  output logic        SDO
);

  logic csx_s, csx_rise, csx_fall;
  logic sck_s, sck_rise, sck_fall;
  logic sdi_s, sdi_rise, sdi_fall;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csx (
    .clk(clk), .rst_n(rst_n), .din(CSX), .level(csx_s), .rise(csx_rise), .fall(csx_fall)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .din(SCK), .level(sck_s), .rise(sck_rise), .fall(sck_fall)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk(clk), .rst_n(rst_n), .din(SDI), .level(sdi_s), .rise(sdi_rise), .fall(sdi_fall)
  );

  logic unused_sigs;
  assign unused_sigs = ^{sck_s, sdi_rise, sdi_fall, in[14:8]};

  state_t     state_reg, state_next;
  logic [7:0] shift_reg;
  logic [2:0] bitcnt_reg;
  logic       armed_reg;
  logic       smp_reg;
  logic [7:0] rx_data_reg;
  logic       rx_full_reg;
  logic       overrun_reg;
  logic [7:0] tx_buf_reg;
  logic       tx_empty_reg;

  logic sel, reload, bit_rise, bit_fall, byte_done;
  logic tx_write, ack, rx_full_acked, overrun_acked;

  assign sel = ~csx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (csx_fall) state_next = ST_ACTIVE;
      ST_ACTIVE: if (csx_rise) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // A deselect in the same cycle as an SCK edge suppresses that edge entirely.
  always_comb begin
    reload   = 1'b0;
    bit_rise = 1'b0;
    bit_fall = 1'b0;
    case (state_reg)
      ST_IDLE:   reload = csx_fall;
      ST_ACTIVE: begin
        if (!csx_rise) begin
          bit_rise = sck_rise;
          bit_fall = sck_fall;
          reload   = sck_fall & armed_reg;
        end
      end
      default: ;
    endcase
  end

  assign byte_done     = bit_rise & (bitcnt_reg == 3'd7);
  assign tx_write      = load & ~in[CMD_ACK];
  assign ack           = load & in[CMD_ACK];
  assign rx_full_acked = rx_full_reg & ~ack;
  assign overrun_acked = overrun_reg & ~ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg    <= FILL;
      bitcnt_reg   <= 3'd0;
      armed_reg    <= 1'b0;
      smp_reg      <= 1'b0;
      rx_data_reg  <= 8'h00;
      rx_full_reg  <= 1'b0;
      overrun_reg  <= 1'b0;
      tx_buf_reg   <= 8'h00;
      tx_empty_reg <= 1'b1;
    end else begin
      if (csx_rise || (state_reg == ST_IDLE && csx_fall)) begin
        bitcnt_reg <= 3'd0;
        armed_reg  <= 1'b0;
      end else if (bit_rise) begin
        smp_reg <= sdi_s;
        if (byte_done) begin
          bitcnt_reg  <= 3'd0;
          armed_reg   <= 1'b1;
          rx_data_reg <= {shift_reg[6:0], sdi_s};
        end else begin
          bitcnt_reg <= bitcnt_reg + 3'd1;
        end
      end else if (bit_fall) begin
        armed_reg <= 1'b0;
      end

      if (reload)        shift_reg <= tx_empty_reg ? FILL : tx_buf_reg;
      else if (bit_fall) shift_reg <= {shift_reg[6:0], smp_reg};

      // A CPU write lands after a same-cycle reload, so the new byte waits.
      if (tx_write) begin
        tx_buf_reg   <= in[7:0];
        tx_empty_reg <= 1'b0;
      end else if (reload) begin
        tx_empty_reg <= 1'b1;
      end

      rx_full_reg <= rx_full_acked | byte_done;
      overrun_reg <= overrun_acked | (byte_done & rx_full_acked);
    end
  end

  always_comb begin
    out      = 16'h0000;
    out[RXF] = rx_full_reg;
    out[OVR] = overrun_reg;
    out[SEL] = sel;
    out[TXE] = tx_empty_reg;
    out[7:0] = rx_data_reg;
  end

  assign SDO = sel & shift_reg[7];

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a mode-0 SPI master model plus CPU
// writes, with expected MISO bytes and status words queued per transaction.
module tb_spi_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] in = 16'h0000;
  logic [15:0] out;
  logic        CSX = 1'b1;
  logic        SCK = 1'b0;
  logic        SDI = 1'b0;
  logic        SDO;

  int checks = 0;
  int errs = 0;
  logic [7:0]  miso_q[$];
  logic [15:0] out_q[$];
  logic [7:0]  rx_b, exp_b;
  logic [15:0] exp_w;

  spi_slave #(.FILL(8'hFF), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .in(in), .out(out),
    .CSX(CSX), .SCK(SCK), .SDI(SDI), .SDO(SDO)
  );

  always #20 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: bench did not finish, out=%h", out);
    $fatal(1, "timeout");
  end

  task automatic cpu_write(input logic [15:0] v);
    @(negedge clk);
    load = 1'b1;
    in   = v;
    @(negedge clk);
    load = 1'b0;
    $display("cpu write in=%h -> out=%h", v, out);
  endtask

  // CSX low; optional CPU write timed to the cycle of the frame-start reload.
  task automatic cs_start(input bit do_load, input logic [15:0] v);
    @(negedge clk);
    CSX = 1'b0;
    repeat (2) @(negedge clk);
    if (do_load) begin
      load = 1'b1;
      in   = v;
    end
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_end();
    @(negedge clk);
    CSX = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // SCK = clk/8. Optional ack lands in the cycle the 8th rise completes the byte.
  task automatic xfer(input logic [7:0] tx, input int nbits, input bit do_ack,
                      output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      SDI = tx[i];
      repeat (4) @(negedge clk);
      rx[i] = SDO;
      SCK = 1'b1;
      if (do_ack && i == 0) begin
        repeat (2) @(negedge clk);
        load = 1'b1;
        in   = 16'h8000;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      SCK = 1'b0;
    end
    $display("xfer bits=%0d mosi=%h miso=%h out=%h", nbits, tx, rx, out);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out !== 16'h0100 || SDO !== 1'b0) begin
        $display("FAIL reset_hold out=%h SDO=%b required out=0100 SDO=0", out, SDO);
        errs++;
      end
      CSX = i[0];
      SCK = ~i[0];
      SDI = 1'b1;
    end
    CSX = 1'b1;
    SCK = 1'b0;
    SDI = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out !== 16'h0100 || SDO !== 1'b0) begin
        $display("FAIL reset_release out=%h SDO=%b required out=0100 SDO=0", out, SDO);
        errs++;
      end
    end
  endtask

  task automatic test_single_byte();
    out_q.push_back(16'h0000);
    cpu_write(16'h00A5);
    exp_w = out_q.pop_front();
    checks++;
    if (out !== exp_w) begin $display("FAIL single_txwrite out=%h required %h", out, exp_w); errs++; end

    miso_q.push_back(8'hA5);
    out_q.push_back(16'hA13C);
    cs_start(1'b0, 16'h0000);
    xfer(8'h3C, 8, 1'b0, rx_b);
    exp_b = miso_q.pop_front();
    checks++;
    if (rx_b !== exp_b) begin $display("FAIL single_miso got=%h required %h", rx_b, exp_b); errs++; end
    exp_w = out_q.pop_front();
    checks++;
    if (out !== exp_w) begin $display("FAIL single_rx out=%h required %h", out, exp_w); errs++; end

    out_q.push_back(16'h813C);
    cs_end();
    exp_w = out_q.pop_front();
    checks++;
    if (out !== exp_w || SDO !== 1'b0) begin
      $display("FAIL single_desel out=%h SDO=%b required %h SDO=0", out, SDO, exp_w);
      errs++;
    end
  endtask

  task automatic test_empty_tx();
    out_q.push_back(16'h013C);
    cpu_write(16'h8000);
    exp_w = out_q.pop_front();
    checks++;
    if (out !== exp_w) begin $display("FAIL empty_ack out=%h required %h", out, exp_w); errs++; end

    miso_q.push_back(8'hFF);
    out_q.push_back(16'hA181);
    out_q.push_back(16'h8181);
    cs_start(1'b0, 16'h0000);
    xfer(8'h81, 8, 1'b0, rx_b);
    exp_b = miso_q.pop_front();
    checks++;
    if (rx_b !== exp_b) begin $display("FAIL empty_fill got=%h required %h", rx_b, exp_b); errs++; end
    exp_w = out_q.pop_front();
    checks++;
    if (out !== exp_w) begin $display("FAIL empty_rx out=%h required %h", out, exp_w); errs++; end
    cs_end();
    exp_w = out_q.pop_front();
    checks++;
    if (out !== exp_w) begin $display("FAIL empty_desel out=%h required %h", out, exp_w); errs++; end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    bytes = '{8'h11, 8'h22, 8'h33};
    out_q.push_back(16'h0181);
    cpu_write(16'h8000);
    exp_w = out_q.pop_front();
    checks++;
    if (out !== exp_w) begin $display("FAIL b2b_ack0 out=%h required %h", out, exp_w); errs++; end

    cs_start(1'b0, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      miso_q.push_back(8'hFF);
      xfer(bytes[k], 8, 1'b0, rx_b);
      exp_b = miso_q.pop_front();
      checks++;
      if (rx_b !== exp_b) begin $display("FAIL b2b_miso%0d got=%h required %h", k, rx_b, exp_b); errs++; end
    end
    out_q.push_back(16'hE133);
    exp_w = out_q.pop_front();
    checks++;
    if (out !== exp_w) begin $display("FAIL b2b_overrun out=%h required %h", out, exp_w); errs++; end

    out_q.push_back(16'h2133);
    cpu_write(16'h8000);
    exp_w = out_q.pop_front();
    checks++;
    if (out !== exp_w) begin $display("FAIL b2b_ack out=%h required %h", out, exp_w); errs++; end

    out_q.push_back(16'h0133);
    cs_end();
    exp_w = out_q.pop_front();
    checks++;
    if (out !== exp_w) begin $display("FAIL b2b_desel out=%h required %h", out, exp_w); errs++; end
  endtask

  task automatic test_abort();
    out_q.push_back(16'h0033);
    cpu_write(16'h00C3);
    exp_w = out_q.pop_front();
    checks++;
    if (out !== exp_w) begin $display("FAIL abort_txwrite out=%h required %h", out, exp_w); errs++; end

    cs_start(1'b0, 16'h0000);
    xfer(8'hA0, 4, 1'b0, rx_b);
    checks++;
    if (rx_b[7:4] !== 4'hC) begin $display("FAIL abort_partial_miso got=%h required c", rx_b[7:4]); errs++; end

    out_q.push_back(16'h0133);
    cs_end();
    exp_w = out_q.pop_front();
    checks++;
    if (out !== exp_w) begin $display("FAIL abort_status out=%h required %h", out, exp_w); errs++; end

    miso_q.push_back(8'hFF);
    out_q.push_back(16'hA15E);
    out_q.push_back(16'h815E);
    cs_start(1'b0, 16'h0000);
    xfer(8'h5E, 8, 1'b0, rx_b);
    exp_b = miso_q.pop_front();
    checks++;
    if (rx_b !== exp_b) begin $display("FAIL abort_fill got=%h required %h", rx_b, exp_b); errs++; end
    exp_w = out_q.pop_front();
    checks++;
    if (out !== exp_w) begin $display("FAIL abort_rx out=%h required %h", out, exp_w); errs++; end
    cs_end();
    exp_w = out_q.pop_front();
    checks++;
    if (out !== exp_w) begin $display("FAIL abort_desel out=%h required %h", out, exp_w); errs++; end
  endtask

  task automatic test_simul_ack();
    miso_q.push_back(8'hFF);
    out_q.push_back(16'hA177);
    out_q.push_back(16'h8177);
    cs_start(1'b0, 16'h0000);
    xfer(8'h77, 8, 1'b1, rx_b);
    exp_b = miso_q.pop_front();
    checks++;
    if (rx_b !== exp_b) begin $display("FAIL sack_miso got=%h required %h", rx_b, exp_b); errs++; end
    exp_w = out_q.pop_front();
    checks++;
    if (out !== exp_w) begin $display("FAIL sack_status out=%h required %h", out, exp_w); errs++; end
    cs_end();
    exp_w = out_q.pop_front();
    checks++;
    if (out !== exp_w) begin $display("FAIL sack_desel out=%h required %h", out, exp_w); errs++; end
  endtask

  task automatic test_simul_tx();
    out_q.push_back(16'h0177);
    cpu_write(16'h8000);
    exp_w = out_q.pop_front();
    checks++;
    if (out !== exp_w) begin $display("FAIL stx_ack out=%h required %h", out, exp_w); errs++; end
    out_q.push_back(16'h0077);
    cpu_write(16'h005A);
    exp_w = out_q.pop_front();
    checks++;
    if (out !== exp_w) begin $display("FAIL stx_write out=%h required %h", out, exp_w); errs++; end

    out_q.push_back(16'h2077);
    cs_start(1'b1, 16'h0096);
    exp_w = out_q.pop_front();
    checks++;
    if (out !== exp_w) begin $display("FAIL stx_reload out=%h required %h", out, exp_w); errs++; end

    miso_q.push_back(8'h5A);
    miso_q.push_back(8'h96);
    out_q.push_back(16'hA001);
    out_q.push_back(16'hE102);
    xfer(8'h01, 8, 1'b0, rx_b);
    exp_b = miso_q.pop_front();
    checks++;
    if (rx_b !== exp_b) begin $display("FAIL stx_old_byte got=%h required %h", rx_b, exp_b); errs++; end
    exp_w = out_q.pop_front();
    checks++;
    if (out !== exp_w) begin $display("FAIL stx_status1 out=%h required %h", out, exp_w); errs++; end
    xfer(8'h02, 8, 1'b0, rx_b);
    exp_b = miso_q.pop_front();
    checks++;
    if (rx_b !== exp_b) begin $display("FAIL stx_new_byte got=%h required %h", rx_b, exp_b); errs++; end
    exp_w = out_q.pop_front();
    checks++;
    if (out !== exp_w) begin $display("FAIL stx_status2 out=%h required %h", out, exp_w); errs++; end

    out_q.push_back(16'hC102);
    cs_end();
    exp_w = out_q.pop_front();
    checks++;
    if (out !== exp_w || SDO !== 1'b0) begin
      $display("FAIL stx_desel out=%h SDO=%b required %h SDO=0", out, SDO, exp_w);
      errs++;
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_empty_tx();
    test_back_to_back();
    test_abort();
    test_simul_ack();
    test_simul_tx();
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

endmodule
